// File: rtl/debug_trace_buffer.sv
// Circular trace buffer for the debug select bus: mask/value trigger, post-trigger count, oldest-first readout.
// Optional trigger timestamp enabled with `define DEBUG_TRACE_STAMP_EN.
module debug_trace_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       trig_stamp
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, post_cnt;
    logic [ADDR_W:0]   fill, rd_left;

    logic              hit, wr_en, rd_en, post_load, post_dec, enter_done;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic [ADDR_W:0]   fill_inc;

    always_comb begin
        hit        = sample_en && ((sample_in & trig_mask) == (trig_value & trig_mask));
        wr_en      = sample_en && !arm && (state == S_ARMED || state == S_POST);
        rd_en      = rd_req && !arm && (state == S_DONE) && (rd_left != '0);
        wr_ptr_inc = wr_ptr + 1'b1;
        fill_inc   = (fill == FULL) ? fill : fill + 1'b1;
    end

    always_comb begin
        state_next = state;
        post_load  = 1'b0;
        post_dec   = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (arm) begin
                    state_next = S_ARMED;
                end else if (hit) begin
                    if (post_len == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_POST;
                        post_load  = 1'b1;
                    end
                end
            end
            S_POST: begin
                if (arm) begin
                    state_next = S_ARMED;
                end else if (sample_en) begin
                    post_dec = 1'b1;
                    if (post_cnt == ADDR_W'(1)) state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (arm) state_next = S_ARMED;
            end
            default: state_next = S_IDLE;
        endcase
        enter_done = (state_next == S_DONE) && (state != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
            rd_left  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy     <= (state_next == S_ARMED) || (state_next == S_POST);
            done     <= (state_next == S_DONE);
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_ptr];
            if (arm) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fill     <= '0;
                post_cnt <= '0;
                rd_left  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr_inc;
                    fill   <= fill_inc;
                end
                if (post_load)     post_cnt <= post_len;
                else if (post_dec) post_cnt <= post_cnt - 1'b1;
                // Entry to DONE always coincides with a write, so use post-write pointer/fill
                if (enter_done) begin
                    rd_ptr  <= (fill_inc == FULL) ? wr_ptr_inc : '0;
                    rd_left <= fill_inc;
                end else if (rd_en) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    rd_left <= rd_left - 1'b1;
                end
            end
        end
    end

`ifdef DEBUG_TRACE_STAMP_EN
    logic [15:0] stamp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_cnt  <= '0;
            trig_stamp <= '0;
        end else if (arm) begin
            stamp_cnt  <= '0;
            trig_stamp <= '0;
        end else if (state == S_ARMED && sample_en) begin
            if (hit) trig_stamp <= stamp_cnt;
            if (stamp_cnt != '1) stamp_cnt <= stamp_cnt + 1'b1;
        end
    end
`else
    assign trig_stamp = '0;
`endif

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed self-checking bench for debug_trace_buffer.
module tb_debug_trace_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arm = 1'b0;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [DATA_W-1:0] trig_mask = '0;
    logic [DATA_W-1:0] trig_value = '0;
    logic [ADDR_W-1:0] post_len = '0;
    logic              rd_req = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [15:0]       trig_stamp;

    int checks = 0;
    int failures = 0;

`ifdef DEBUG_TRACE_STAMP_EN
    localparam logic [15:0] STAMP_EXP = 16'd9;
`else
    localparam logic [15:0] STAMP_EXP = 16'd0;
`endif

    debug_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .sample_en(sample_en), .sample_in(sample_in),
        .trig_mask(trig_mask), .trig_value(trig_value), .post_len(post_len),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .done(done), .trig_stamp(trig_stamp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [7:0] m, input logic [7:0] v, input logic [3:0] pl);
        trig_mask = m; trig_value = v; post_len = pl;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v);
        sample_en = 1'b1; sample_in = v;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (trig_stamp !== 16'h0) begin failures++; $display("FAIL reset_stamp got=%h exp=0000", trig_stamp); end
        rst_n = 1'b1;
        tick();
        // strobes in IDLE are ignored, even with a catch-all trigger
        trig_mask = 8'h00;
        strobe(8'h3C);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_ignore got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_idle_arm();
        trig_mask = 8'hFF; trig_value = 8'h77; post_len = 4'd0;
        arm = 1'b1; sample_en = 1'b1; sample_in = 8'h77;
        tick();
        arm = 1'b0; sample_en = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL idle_arm_state got=%b%b exp=10", busy, done); end
        strobe(8'h77);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL idle_arm_done got=%b exp=1", done); end
        rd_req = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin failures++; $display("FAIL idle_arm_rd0 got=%b/%h exp=1/77", rd_valid, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL idle_arm_rd1 got=%b exp=0", rd_valid); end
        rd_req = 1'b0;
    endtask

    task automatic test_basic();
        do_arm(8'hFF, 8'h05, 4'd2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int i = 1; i <= 8; i++) strobe(8'(i));
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done got=%b%b exp=10", busy, done); end
        rd_req = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin failures++; $display("FAIL basic_rd%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(i)); end
        end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h07) begin failures++; $display("FAIL basic_rd8 got=%b/%h exp=0/07", rd_valid, rd_data); end
        rd_req = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_stay_done got=%b exp=1", done); end
    endtask

    task automatic test_wrap();
        do_arm(8'hFF, 8'h1C, 4'd3);
        for (int i = 0; i < 32; i++) strobe(8'(i));
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", done); end
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(16 + i)) begin failures++; $display("FAIL wrap_rd%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(16 + i)); end
        end
        tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL wrap_rd_extra got=%b exp=0", rd_valid); end
        rd_req = 1'b0;
    endtask

    task automatic test_mask();
        do_arm(8'h80, 8'h80, 4'd0);
        rd_req = 1'b1;
        strobe(8'h10);
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mask_busy_read got=%b/%b exp=0/1", rd_valid, busy); end
        rd_req = 1'b0;
        strobe(8'h7F);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mask_no_trig got=%b exp=0", done); end
        strobe(8'h81);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL mask_done got=%b exp=1", done); end
        rd_req = 1'b1;
        tick();
        checks++; if (rd_data !== 8'h10 || rd_valid !== 1'b1) begin failures++; $display("FAIL mask_rd0 got=%b/%h exp=1/10", rd_valid, rd_data); end
        tick();
        checks++; if (rd_data !== 8'h7F || rd_valid !== 1'b1) begin failures++; $display("FAIL mask_rd1 got=%b/%h exp=1/7f", rd_valid, rd_data); end
        tick();
        checks++; if (rd_data !== 8'h81 || rd_valid !== 1'b1) begin failures++; $display("FAIL mask_rd2 got=%b/%h exp=1/81", rd_valid, rd_data); end
        rd_req = 1'b0;
    endtask

    task automatic test_handshake();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        do_arm(8'h00, 8'h00, 4'd3);
        for (int i = 0; i < 4; i++) strobe(exp_d[i]);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL hs_done got=%b exp=1", done); end
        rd_req = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL hs_latency got=%b exp=0", rd_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin failures++; $display("FAIL hs_rd%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp_d[i]); end
        end
        rd_req = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h44) begin failures++; $display("FAIL hs_pulse got=%b/%h exp=0/44", rd_valid, rd_data); end
    endtask

    task automatic test_restart();
        do_arm(8'hFF, 8'h05, 4'd0);
        strobe(8'h05);
        arm = 1'b1; rd_req = 1'b1;
        tick();
        arm = 1'b0; rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL arm_vs_read got=%b%b%b exp=010", rd_valid, busy, done); end
        trig_mask = 8'hFF; trig_value = 8'hEE; post_len = 4'd5;
        strobe(8'h01);
        strobe(8'hEE);
        strobe(8'h02);
        trig_value = 8'h03; post_len = 4'd0;
        arm = 1'b1; sample_en = 1'b1; sample_in = 8'h99;
        tick();
        arm = 1'b0; sample_en = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL post_rearm got=%b%b exp=10", busy, done); end
        strobe(8'h03);
        rd_req = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h03) begin failures++; $display("FAIL rearm_rd0 got=%b/%h exp=1/03", rd_valid, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rearm_rd1 got=%b exp=0", rd_valid); end
        rd_req = 1'b0;
        do_arm(8'hFF, 8'h05, 4'd4);
        strobe(8'h05);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_rst_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL async_rst got=%b%b%b exp=000", busy, done, rd_valid); end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stamp();
        do_arm(8'hFF, 8'h5A, 4'd1);
        for (int i = 0; i < 9; i++) strobe(8'(i));
        strobe(8'h5A);
        checks++; if (trig_stamp !== STAMP_EXP) begin failures++; $display("FAIL stamp_post got=%0d exp=%0d", trig_stamp, STAMP_EXP); end
        strobe(8'h01);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stamp_done got=%b exp=1", done); end
        rd_req = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        rd_req = 1'b0;
        checks++; if (trig_stamp !== STAMP_EXP) begin failures++; $display("FAIL stamp_hold got=%0d exp=%0d", trig_stamp, STAMP_EXP); end
        do_arm(8'hFF, 8'h5A, 4'd1);
        checks++; if (trig_stamp !== 16'd0) begin failures++; $display("FAIL stamp_clear got=%0d exp=0", trig_stamp); end
    endtask

    initial begin
        test_reset();
        test_idle_arm();
        test_basic();
        test_wrap();
        test_mask();
        test_handshake();
        test_restart();
        test_stamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
